// File: rtl/perceptron_trainer.sv
// Perceptron trainer: threshold activation on the upstream weighted sum, plus the
// perceptron learning rule applied one weight per cycle on a training miss.
// Owns the weight bank that feeds back into the weighted-sum block.
module perceptron_trainer #(
  parameter int unsigned        N          = 8,
  parameter logic signed [31:0] THRESHOLD  = 32'sd0,
  parameter logic signed [31:0] LEARN_RATE = 32'sd1,
  parameter int unsigned        CNT_W      = 16,
  localparam int unsigned       IdxW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sum_valid,
  output logic              sum_ready,
  input  logic [31:0]       sum,
  input  logic [N-1:0]      x,
  input  logic              target,
  input  logic              train_en,
  output logic              y,
  output logic              y_valid,
  output logic              miss,
  output logic [32*N-1:0]   w,
  input  logic              w_load,
  input  logic [IdxW-1:0]   w_load_idx,
  input  logic [31:0]       w_load_data,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic [1:0] {StIdle, StClassify, StUpdate} state_e;

  state_e           state_q;
  logic [N-1:0]     x_q;
  logic             target_q;
  logic             train_q;
  logic             y_q;
  logic             miss_q;
  logic             y_valid_q;
  logic [IdxW-1:0]  idx_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] drop_q;
  logic [31:0]      w_q [N];

  logic             hit;
  logic [31:0]      w_cur;
  logic [32:0]      step;
  logic [32:0]      w_sum;
  logic [31:0]      w_new;

  assign hit = $signed(sum) > THRESHOLD;

  // Learning-rule step for the weight at idx_q; 33-bit signed with saturation, never wraps.
  always_comb begin
    w_cur = w_q[idx_q];
    step  = {LEARN_RATE[31], LEARN_RATE};
    if (target_q) begin
      w_sum = {w_cur[31], w_cur} + step;
    end else begin
      w_sum = {w_cur[31], w_cur} - step;
    end
    if (w_sum[32] != w_sum[31]) begin
      w_new = w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      w_new = w_sum[31:0];
    end
  end

  // Control FSM with registered outputs, counters and the weight bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      target_q  <= 1'b0;
      train_q   <= 1'b0;
      y_q       <= 1'b0;
      miss_q    <= 1'b0;
      y_valid_q <= 1'b0;
      idx_q     <= '0;
      err_q     <= '0;
      drop_q    <= '0;
      for (int i = 0; i < int'(N); i++) begin
        w_q[i] <= '0;
      end
    end else begin
      y_valid_q <= 1'b0;
      // Samples offered while busy are discarded and counted.
      if (sum_valid && (state_q != StIdle) && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (w_load && (32'(w_load_idx) < N)) begin
            w_q[w_load_idx] <= w_load_data;
          end
          if (sum_valid) begin
            x_q       <= x;
            target_q  <= target;
            train_q   <= train_en;
            y_q       <= hit;
            miss_q    <= (hit != target);
            y_valid_q <= 1'b1;
            if ((hit != target) && (err_q != '1)) begin
              err_q <= err_q + 1'b1;
            end
            state_q <= StClassify;
          end
        end
        StClassify: begin
          idx_q <= '0;
          if (miss_q && train_q) begin
            state_q <= StUpdate;
          end else begin
            state_q <= StIdle;
          end
        end
        StUpdate: begin
          if (x_q[idx_q]) begin
            w_q[idx_q] <= w_new;
          end
          if (idx_q == IdxW'(N - 1)) begin
            idx_q   <= '0;
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar gi = 0; gi < int'(N); gi++) begin : g_wbus
    assign w[32*gi +: 32] = w_q[gi];
  end

  assign sum_ready  = (state_q == StIdle);
  assign y          = y_q;
  assign y_valid    = y_valid_q;
  assign miss       = miss_q;
  assign err_count  = err_q;
  assign drop_count = drop_q;

endmodule
